rca_nibble_seq_adder: RTL and testbench
=======================================

// Module: rca_nibble_seq_adder
// PURPOSE
//   Multi-cycle WIDTH-bit adder that drives one internal rca_4bit instance one nibble per cycle, LSB nibble first.
//   Sits directly upstream of rca_4bit: it latches full-width operands, feeds nibbles and the registered carry into
//   the adder, and collects sum nibbles and carry-out. Valid/ready on both sides; one operation in flight at a time.
// PARAMETERS
//   WIDTH   16   operand/result width in bits; must be a multiple of 4 and >= 4 (otherwise elaboration error)
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operand request valid
//   in_ready   out  1      block can accept an operand request this cycle
//   op_a       in   WIDTH  addend A
//   op_b       in   WIDTH  addend B
//   c_in       in   1      carry into bit 0
//   out_valid  out  1      sum/c_out valid; held until consumed
//   out_ready  in   1      downstream accepts result
//   sum        out  WIDTH  A + B + c_in, low WIDTH bits
//   c_out      out  1      carry out of bit WIDTH-1
//   busy       out  1      high in ADD and DONE
// BEHAVIOUR
//   - N = WIDTH/4 nibble steps. FSM states: IDLE, ADD, DONE.
//   - Reset (asynchronous assertion, any state including mid-ADD): state=IDLE, nibble index=0, carry reg=0,
//     operand/sum regs=0; outputs in_ready=1, out_valid=0, sum=0, c_out=0, busy=0. In-flight op discarded.
//   - in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready.
//   - Accept edge: latch op_a/op_b, carry<=c_in, idx<=0, state<=ADD. out_valid drops on this edge when leaving DONE.
//   - ADD, each edge: rca_4bit inputs A=opa[3:0], B=opb[3:0], c_in=carry; sum reg shifts right 4 with rca sum in
//     top nibble; operands shift right 4; carry<=rca c_out; idx++.
//     On the edge with idx==N-1: c_out<=rca c_out, state<=DONE, out_valid<=1.
//   - Latency: out_valid high exactly N edges after accept edge (WIDTH=16 -> 4). Throughput: one op per N+1 cycles
//     without stalls (accept in DONE allowed on the same edge out_ready consumes the result).
//   - in_valid during ADD is ignored (in_ready=0); request must be held by sender until accepted.
//   - DONE with out_ready=0: sum, c_out, out_valid held stable indefinitely; in_ready=0.
//   - DONE, out_ready=1, in_valid=0: state<=IDLE, out_valid<=0; sum/c_out retain last value.
//   - Arithmetic is unsigned modulo 2^WIDTH; no overflow flag. WIDTH=4: single ADD cycle.
//   - Carry ripples between nibbles only through the carry register; no combinational path from op_* to outputs.
// CONFIGURATION
//   RCA_SEQ_SUB_EN defined: extra input port sub (1 bit, sampled with op_a/op_b on accept). sub=1 latches ~op_b and
//     forces carry<=1 (c_in ignored); result = A - B mod 2^WIDTH, c_out=1 means no borrow. sub=0 behaves as add.
//   RCA_SEQ_SUB_EN undefined: no sub port; add only; logic otherwise identical.
// TESTING (WIDTH=16)
//   1) Accept 0x1234+0x4321, c_in=0, out_ready=1 -> out_valid 4 cycles later, sum=0x5555, c_out=0.
//   2) 0xFFFF+0x0001, c_in=0 -> sum=0x0000, c_out=1 (carry crosses all nibble boundaries); 0x0000+0x0000,c_in=1 -> 0x0001.
//   3) Result ready, out_ready=0 for 3 cycles with in_valid=1 -> sum/c_out/out_valid stable, in_ready=0; then
//      out_ready=1 -> new op accepted same edge, out_valid low next cycle, next result 4 cycles later.
//   4) rst_n low during 2nd ADD cycle -> immediately in_ready=1, out_valid=0, busy=0; next op 0x00FF+0x0001 -> 0x0100.
//   5) Back-to-back 8 random ops with out_ready=1 -> one result every 5 cycles, all match golden A+B+c_in.
//   6) With RCA_SEQ_SUB_EN: sub=1, 0x0005-0x0007 -> sum=0xFFFE, c_out=0; 0x0007-0x0005 -> 0x0002, c_out=1.

Source files
------------

// File: rtl/rca_nibble_seq_adder_if.sv
// Valid/ready request and result bundle for rca_nibble_seq_adder.
// Optional macro RCA_SEQ_SUB_EN adds the 'sub' request field.
interface rca_nibble_seq_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             c_in;
`ifdef RCA_SEQ_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             busy;

  modport master (
`ifdef RCA_SEQ_SUB_EN
    output sub,
`endif
    output in_valid, op_a, op_b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, busy
  );

  modport slave (
`ifdef RCA_SEQ_SUB_EN
    input  sub,
`endif
    input  in_valid, op_a, op_b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, busy
  );
endinterface

// File: rtl/rca_nibble_seq_adder.sv
// Multi-cycle WIDTH-bit adder stepping one 4-bit ripple-carry adder per nibble, LSB first.
// Optional macro RCA_SEQ_SUB_EN enables subtraction via the 'sub' request field.

module rca_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_sum,
  output logic       o_c
);
  logic [4:0] w_c;

  assign w_c[0] = i_c;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_c = w_c[4];
endmodule

module rca_nibble_seq_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rca_nibble_seq_adder_if.slave bus
);
  localparam int unsigned N     = WIDTH / 4;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("rca_nibble_seq_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_out_valid;

  logic             w_in_ready;
  logic             w_accept;
  logic [3:0]       w_nib_sum;
  logic             w_nib_c;
  logic [WIDTH-1:0] w_sum_shift;
  logic [WIDTH-1:0] w_opb_load;
  logic             w_carry_load;

  assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  rca_4bit u_rca (
    .i_a   (r_opa[3:0]),
    .i_b   (r_opb[3:0]),
    .i_c   (r_carry),
    .o_sum (w_nib_sum),
    .o_c   (w_nib_c)
  );

  // New sum nibble enters at the top so the LSB nibble ends up in place after N steps.
  if (N == 1) begin : g_one_nib
    assign w_sum_shift = WIDTH'(w_nib_sum);
  end else begin : g_multi_nib
    assign w_sum_shift = {w_nib_sum, r_sum[WIDTH-1:4]};
  end

  // Operand B and initial carry as captured on accept (inverted B plus one for subtract).
  always_comb begin
    w_opb_load   = bus.op_b;
    w_carry_load = bus.c_in;
`ifdef RCA_SEQ_SUB_EN
    if (bus.sub) begin
      w_opb_load   = ~bus.op_b;
      w_carry_load = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_opa   <= bus.op_a;
            r_opb   <= w_opb_load;
            r_carry <= w_carry_load;
            r_idx   <= '0;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_sum   <= w_sum_shift;
          r_opa   <= r_opa >> 4;
          r_opb   <= r_opb >> 4;
          r_carry <= w_nib_c;
          r_idx   <= r_idx + IDX_W'(1);
          if (r_idx == IDX_W'(N - 1)) begin
            r_cout      <= w_nib_c;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (w_accept) begin
            r_opa       <= bus.op_a;
            r_opb       <= w_opb_load;
            r_carry     <= w_carry_load;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_state     <= S_ADD;
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.c_out     = r_cout;
  assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_rca_nibble_seq_adder.sv
// Directed self-checking bench for rca_nibble_seq_adder (WIDTH=16).
// Subtract vectors run when RCA_SEQ_SUB_EN is defined.
module tb_rca_nibble_seq_adder;
  localparam int unsigned WIDTH = 16;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  rca_nibble_seq_adder_if #(.WIDTH(WIDTH)) bus ();

  rca_nibble_seq_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Single operation from IDLE with out_ready=1: 4-edge latency, then return to IDLE.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic [15:0] exp_sum, input logic exp_c);
    bus.op_a     = a;
    bus.op_b     = b;
    bus.c_in     = ci;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
    tick(); tick(); tick();
    chk({tag, ".early_valid"}, 32'(bus.out_valid), 32'd0);
    tick();
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".sum"}, 32'(bus.sum), 32'(exp_sum));
    chk({tag, ".c_out"}, 32'(bus.c_out), 32'(exp_c));
    tick();
    chk({tag, ".idle_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".sum_kept"}, 32'(bus.sum), 32'(exp_sum));
  endtask

  initial begin
    logic [15:0] ra [8];
    logic [15:0] rb [8];
    logic        rc [8];
    logic [16:0] gold;

    n_cmp         = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.c_in      = 1'b0;
    bus.out_ready = 1'b1;
`ifdef RCA_SEQ_SUB_EN
    bus.sub       = 1'b0;
`endif
    tick(); tick();
    chk("rst.in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.sum",       32'(bus.sum),       32'd0);
    chk("rst.c_out",     32'(bus.c_out),     32'd0);
    chk("rst.busy",      32'(bus.busy),      32'd0);
    rst_n = 1'b1;
    tick();

    do_op("t1",    16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    do_op("t2a",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    do_op("t2b",   16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);
    do_op("t2c",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    do_op("t2d",   16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    do_op("t2e",   16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);

    // Result stalled by out_ready=0 while a second request waits
    bus.out_ready = 1'b0;
    bus.op_a      = 16'h0101;
    bus.op_b      = 16'h0202;
    bus.c_in      = 1'b0;
    bus.in_valid  = 1'b1;
    tick();
    bus.op_a = 16'h1111;
    bus.op_b = 16'h2222;
    bus.c_in = 1'b1;
    chk("t3.add_in_ready", 32'(bus.in_ready), 32'd0);
    tick(); tick(); tick(); tick();
    chk("t3.valid", 32'(bus.out_valid), 32'd1);
    chk("t3.sum",   32'(bus.sum),       32'h0303);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3.hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t3.hold_sum",   32'(bus.sum),       32'h0303);
      chk("t3.hold_c",     32'(bus.c_out),     32'd0);
      chk("t3.hold_ready", 32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("t3.ready_same", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("t3.drop_valid", 32'(bus.out_valid), 32'd0);
    chk("t3.busy",       32'(bus.busy),      32'd1);
    tick(); tick(); tick();
    chk("t3.early", 32'(bus.out_valid), 32'd0);
    tick();
    chk("t3.valid2", 32'(bus.out_valid), 32'd1);
    chk("t3.sum2",   32'(bus.sum),       32'h3334);
    chk("t3.c2",     32'(bus.c_out),     32'd0);
    tick();

    // Reset asserted in the second ADD cycle
    bus.op_a     = 16'hAAAA;
    bus.op_b     = 16'h5555;
    bus.c_in     = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t4.in_ready",  32'(bus.in_ready),  32'd1);
    chk("t4.out_valid", 32'(bus.out_valid), 32'd0);
    chk("t4.busy",      32'(bus.busy),      32'd0);
    chk("t4.sum",       32'(bus.sum),       32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_op("t4.after", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

    // Back-to-back random ops, one result every 5 cycles
    for (int k = 0; k < 8; k++) begin
      ra[k] = 16'($urandom);
      rb[k] = 16'($urandom);
      rc[k] = 1'($urandom);
    end
    bus.out_ready = 1'b1;
    bus.op_a      = ra[0];
    bus.op_b      = rb[0];
    bus.c_in      = rc[0];
    bus.in_valid  = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      tick(); tick(); tick();
      chk("t5.early", 32'(bus.out_valid), 32'd0);
      tick();
      gold = 17'(ra[k]) + 17'(rb[k]) + 17'(rc[k]);
      chk("t5.valid", 32'(bus.out_valid), 32'd1);
      chk("t5.sum",   32'(bus.sum),       32'(gold[15:0]));
      chk("t5.c_out", 32'(bus.c_out),     32'(gold[16]));
      if (k < 7) begin
        bus.op_a = ra[k+1];
        bus.op_b = rb[k+1];
        bus.c_in = rc[k+1];
        #1;
        chk("t5.in_ready", 32'(bus.in_ready), 32'd1);
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      chk("t5.drop", 32'(bus.out_valid), 32'd0);
    end

`ifdef RCA_SEQ_SUB_EN
    bus.sub = 1'b1;
    do_op("t6a", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
    do_op("t6b", 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
    bus.sub = 1'b0;
    do_op("t6c", 16'h0007, 16'h0005, 1'b0, 16'h000C, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
